wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back end of the execute-stage result path. It captures the per-instruction write request produced by the execute units (ex_we_i, ex_waddr_i, ex_wdata_i) into a single EX/WB pipeline register. It commits that request into the 32x32 integer register file. It serves two read ports to decode, with EX→read and WB→read forwarding so back-to-back dependent instructions see fresh values.

Parameters:
DATA_WIDTH, 32, register and data width in bits
REG_NUM, 32, number of architectural registers (x0..x31)
ADDR_WIDTH, 5, register index width; must equal log2(REG_NUM)

Ports:
clk_i  input  1  core clock; all state updates on rising edge
rst_n_i  input  1  reset, asynchronous assert, active-low
ex_we_i  input  1  execute unit requests a register write this cycle
ex_waddr_i  input  ADDR_WIDTH  destination register (rd) of the execute result
ex_wdata_i  input  DATA_WIDTH  execute result
hold_i  input  1  pipeline stall; the EX/WB register keeps its contents
flush_i  input  1  kill the instruction currently in EX; its write must not reach WB
raddr1_i  input  ADDR_WIDTH  read port 1 index (rs1)
raddr2_i  input  ADDR_WIDTH  read port 2 index (rs2)
rdata1_o  output  DATA_WIDTH  read port 1 data, combinational
rdata2_o  output  DATA_WIDTH  read port 2 data, combinational
wb_we_o  output  1  EX/WB register: write pending
wb_waddr_o  output  ADDR_WIDTH  EX/WB register: destination
wb_wdata_o  output  DATA_WIDTH  EX/WB register: data
wr_cnt_o  output  32  count of writes accepted into EX/WB, wraps modulo 2^32

Behaviour:
- Reset (rst_n_i=0, asynchronous, any time including mid-stall):
  - all REG_NUM registers cleared to 0
  - wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0, wr_cnt_o=0
  - reads return 0 while reset is asserted
- EX/WB register, on each rising edge, in priority order:
  - flush_i=1: wb_we_o←0; addr/data don't-care but cleared to 0. flush_i overrides hold_i.
  - hold_i=1: all wb_* hold.
  - Otherwise: wb_we_o←ex_we_i & (ex_waddr_i≠0); wb_waddr_o←ex_waddr_i; wb_wdata_o←ex_wdata_i.
- Latency: an EX result appears on wb_* 1 cycle after it is presented and is committed to the array at the next edge (2 edges total).
- Commit:
  - On every rising edge with wb_we_o=1, array[wb_waddr_o]←wb_wdata_o.
  - Repeated commits during hold_i are idempotent and allowed.
  - A write to x0 never changes x0.
- wr_cnt_o: +1 on an edge where the EX/WB register loads with ex_we_i=1 and ex_waddr_i≠0 (not flush, not hold); wraps 0xFFFFFFFF→0.
- Read ports (identical logic per port), combinational, in priority order:
  1. raddr=0 → 0 (always, even if a forward targets x0)
  2. ex_we_i=1, flush_i=0, hold_i=0, and ex_waddr_i=raddr → ex_wdata_i (youngest wins)
  3. wb_we_o=1 and wb_waddr_o=raddr → wb_wdata_o
  4. otherwise → array[raddr]
- Simultaneous EX and WB writes to the same rd: the EX value is forwarded; the WB value commits to the array and is overwritten one cycle later. Reads never see the stale value.
- No reg_we-style disable path: an invalid instruction reaches this block as ex_we_i=0.

Decomposition:
- defines.v gains REG_NUM, REG_ADDR_WIDTH and ZERO_REG (5'd0), and reuses the existing DATA_WIDTH, ZERO, WRITE_ENABLE and WRITE_DISABLE.
- One sub-module, regfile_array:
  - storage, with the async active-low clear
  - single synchronous write port, x0-protected
  - two raw combinational read ports
- wb_regfile owns the EX/WB register, the counter and the forwarding muxes.

Test Plan:
- Reset, then read x1..x31 → all 0. Release reset; ex_we_i=1, rd=5, data=0x1234_5678 for one cycle. Read rs1=5: 0x1234_5678 in the same cycle (EX fwd), the next cycle (WB fwd), and after 2 edges (array). wr_cnt_o=1.
- ex_we_i=1, rd=0, data=0xFFFF_FFFF → rdata of x0 stays 0 every cycle, wb_we_o=0, wr_cnt_o unchanged.
- Back-to-back writes: rd=7←0xA, then rd=7←0xB on the next cycle; read x7 each cycle → 0xA, 0xB, 0xB; array holds 0xB.
- Present rd=3←0x55 with flush_i=1 → rdata for x3 is not 0x55 in that cycle; wb_we_o=0 next cycle; x3 stays 0; counter unchanged.
- rd=9←0x99 latched into WB, then hold_i=1 for 3 cycles while EX presents rd=9←0x77 → wb_* stay 0x99, read x9=0x99. After release the next edge loads 0x77.
- Assert rst_n_i low mid-stream, between clock edges, with wb_we_o=1 → wb_we_o, wr_cnt_o and all registers go to 0 immediately, without waiting for an edge. Preload wr_cnt_o to 0xFFFF_FFFF via writes/force; one more write → 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file slice.
// Latency: none, constants and one helper function only.
// Backpressure: none.
package wb_regfile_pkg;

  localparam int          CNT_WIDTH     = 32;
  localparam logic [4:0]  ZERO_REG      = 5'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  // A write is architecturally real only when enabled and not aimed at x0.
  function automatic logic is_real_write(input logic we, input logic [4:0] addr);
    return (we == WRITE_ENABLE) && (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// Integer register storage: one synchronous write port, two raw read ports.
// Latency: write visible after the clock edge; reads are combinational.
// Backpressure: none, writes are always accepted; writes to x0 are dropped.
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] mem [REG_NUM];

  // Storage: cleared asynchronously, x0 never written.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (is_real_write(we_i, waddr_i)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem[raddr1_i];
  assign rdata2_o = mem[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// EX/WB pipeline register, write counter and forwarding read ports over the register array.
// Latency: EX result on wb_* after 1 edge, in the array after 2; reads are combinational with forwarding.
// Backpressure: hold_i freezes EX/WB (commit repeats idempotently); flush_i drops the EX write.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_waddr_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

  logic                  wb_we_q;
  logic [ADDR_WIDTH-1:0] wb_waddr_q;
  logic [DATA_WIDTH-1:0] wb_wdata_q;
  logic [CNT_WIDTH-1:0]  wr_cnt_q;
  logic [DATA_WIDTH-1:0] raw1;
  logic [DATA_WIDTH-1:0] raw2;
  logic                  ex_load;
  logic                  ex_fwd_en;

  // The EX instruction advances only when neither flushed nor stalled.
  assign ex_load   = !flush_i && !hold_i;
  assign ex_fwd_en = ex_load && (ex_we_i == WRITE_ENABLE);

  // EX/WB register: flush beats hold, hold beats load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_we_q    <= WRITE_DISABLE;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else if (flush_i) begin
      wb_we_q    <= WRITE_DISABLE;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else if (!hold_i) begin
      wb_we_q    <= is_real_write(ex_we_i, ex_waddr_i);
      wb_waddr_q <= ex_waddr_i;
      wb_wdata_q <= ex_wdata_i;
    end
  end

  // Count real writes entering EX/WB; wraps naturally at the counter width.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_cnt_q <= '0;
    end else if (ex_load && is_real_write(ex_we_i, ex_waddr_i)) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  regfile_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (wb_we_q),
    .waddr_i  (wb_waddr_q),
    .wdata_i  (wb_wdata_q),
    .raddr1_i (raddr1_i),
    .raddr2_i (raddr2_i),
    .rdata1_o (raw1),
    .rdata2_o (raw2)
  );

  // x0 first, then the youngest in-flight write (EX), then WB, then storage.
  // Reset forces zero so a live EX forward cannot leak through while clearing.
  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic                  rst_n,
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic                  ex_en,
    input logic [ADDR_WIDTH-1:0] ex_addr,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  wb_en,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0] wb_data,
    input logic [DATA_WIDTH-1:0] raw
  );
    if (!rst_n || raddr == ZERO_REG) return '0;
    if (ex_en && ex_addr == raddr)   return ex_data;
    if (wb_en && wb_addr == raddr)   return wb_data;
    return raw;
  endfunction

  // Read port 1 with forwarding.
  always_comb begin
    rdata1_o = read_mux(rst_n_i, raddr1_i, ex_fwd_en, ex_waddr_i, ex_wdata_i,
                        wb_we_q, wb_waddr_q, wb_wdata_q, raw1);
  end

  // Read port 2 with forwarding.
  always_comb begin
    rdata2_o = read_mux(rst_n_i, raddr2_i, ex_fwd_en, ex_waddr_i, ex_wdata_i,
                        wb_we_q, wb_waddr_q, wb_wdata_q, raw2);
  end

  assign wb_we_o    = wb_we_q;
  assign wb_waddr_o = wb_waddr_q;
  assign wb_wdata_o = wb_wdata_q;
  assign wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: forwarding, x0, flush, hold, async reset, counter wrap.
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// Expected values are hand-computed constants.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        hold;
  logic        flush;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ex_we_i    (ex_we),
    .ex_waddr_i (ex_waddr),
    .ex_wdata_i (ex_wdata),
    .hold_i     (hold),
    .flush_i    (flush),
    .raddr1_i   (raddr1),
    .raddr2_i   (raddr2),
    .rdata1_o   (rdata1),
    .rdata2_o   (rdata2),
    .wb_we_o    (wb_we),
    .wb_waddr_o (wb_waddr),
    .wb_wdata_o (wb_wdata),
    .wr_cnt_o   (wr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where new inputs are applied.
  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic ex(input logic we, input logic [4:0] a, input logic [31:0] d);
    ex_we = we; ex_waddr = a; ex_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    ex(1'b0, 5'd0, 32'h0);
    raddr1 = 5'd0; raddr2 = 5'd0;
    #2;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i + 1);
      #1;
      chk("rst_rd1", rdata1, 32'h0);
      chk("rst_rd2", rdata2, 32'h0);
    end
    chk("rst_wb_we", {31'd0, wb_we}, 32'h0);
    chk("rst_wb_addr", {27'd0, wb_waddr}, 32'h0);
    chk("rst_wb_data", wb_wdata, 32'h0);
    chk("rst_cnt", wr_cnt, 32'h0);
    // A live EX forward must not leak while reset is held.
    ex(1'b1, 5'd4, 32'hDEAD_BEEF); raddr1 = 5'd4; #1;
    chk("rst_no_fwd", rdata1, 32'h0);
    ex(1'b0, 5'd0, 32'h0);

    nedge(); rst_n = 1'b1;

    // Single write to x5: EX forward, WB forward, then storage.
    nedge(); ex(1'b1, 5'd5, 32'h1234_5678); raddr1 = 5'd5; #1;
    chk("x5_ex_fwd", rdata1, 32'h1234_5678);
    nedge(); ex(1'b0, 5'd0, 32'h0); raddr2 = 5'd5; #1;
    chk("x5_wb_fwd", rdata1, 32'h1234_5678);
    chk("x5_wb_fwd_p2", rdata2, 32'h1234_5678);
    chk("x5_wb_we", {31'd0, wb_we}, 32'h1);
    chk("x5_wb_addr", {27'd0, wb_waddr}, 32'h5);
    chk("cnt_1", wr_cnt, 32'h1);
    nedge(); #1;
    chk("x5_array", rdata1, 32'h1234_5678);
    chk("x5_wb_idle", {31'd0, wb_we}, 32'h0);

    // Write to x0 is ignored everywhere.
    nedge(); ex(1'b1, 5'd0, 32'hFFFF_FFFF); raddr1 = 5'd0; raddr2 = 5'd0; #1;
    chk("x0_rd1_ex", rdata1, 32'h0);
    chk("x0_rd2_ex", rdata2, 32'h0);
    nedge(); ex(1'b0, 5'd0, 32'h0); #1;
    chk("x0_rd1_wb", rdata1, 32'h0);
    chk("x0_wb_we", {31'd0, wb_we}, 32'h0);
    chk("x0_cnt", wr_cnt, 32'h1);
    nedge(); #1;
    chk("x0_rd1_arr", rdata1, 32'h0);

    // Back-to-back writes to x7: EX value must beat the older WB value.
    nedge(); ex(1'b1, 5'd7, 32'hA); raddr1 = 5'd7; raddr2 = 5'd5; #1;
    chk("x7_a", rdata1, 32'hA);
    nedge(); ex(1'b1, 5'd7, 32'hB); #1;
    chk("x7_b_ex", rdata1, 32'hB);
    nedge(); ex(1'b0, 5'd0, 32'h0); #1;
    chk("x7_b_wb", rdata1, 32'hB);
    nedge(); #1;
    chk("x7_b_arr", rdata1, 32'hB);
    chk("x5_keep", rdata2, 32'h1234_5678);
    chk("cnt_3", wr_cnt, 32'h3);

    // Flushed write to x3 never lands.
    nedge(); ex(1'b1, 5'd3, 32'h55); flush = 1'b1; raddr1 = 5'd3; #1;
    chk("x3_flush_rd", rdata1, 32'h0);
    nedge(); ex(1'b0, 5'd0, 32'h0); flush = 1'b0; #1;
    chk("x3_flush_we", {31'd0, wb_we}, 32'h0);
    chk("x3_flush_data", wb_wdata, 32'h0);
    chk("x3_flush_cnt", wr_cnt, 32'h3);
    nedge(); #1;
    chk("x3_flush_arr", rdata1, 32'h0);

    // Hold keeps x9=0x99 in WB while EX presents 0x77.
    nedge(); ex(1'b1, 5'd9, 32'h99); raddr1 = 5'd9; #1;
    chk("x9_ex", rdata1, 32'h99);
    nedge(); ex(1'b1, 5'd9, 32'h77); hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("x9_hold_we", {31'd0, wb_we}, 32'h1);
      chk("x9_hold_data", wb_wdata, 32'h99);
      chk("x9_hold_rd", rdata1, 32'h99);
      chk("x9_hold_cnt", wr_cnt, 32'h4);
      nedge();
    end
    hold = 1'b0; #1;
    chk("x9_rel_ex", rdata1, 32'h77);
    nedge(); ex(1'b0, 5'd0, 32'h0); #1;
    chk("x9_rel_wb", wb_wdata, 32'h77);
    chk("x9_rel_cnt", wr_cnt, 32'h5);
    nedge(); #1;
    chk("x9_arr", rdata1, 32'h77);

    // Flush overrides hold; the pending WB commit still lands in storage.
    nedge(); ex(1'b1, 5'd10, 32'h10); raddr1 = 5'd10;
    nedge(); ex(1'b1, 5'd10, 32'h20); hold = 1'b1; flush = 1'b1; #1;
    chk("fh_wb_pend", {31'd0, wb_we}, 32'h1);
    chk("fh_rd_wb", rdata1, 32'h10);
    nedge(); ex(1'b0, 5'd0, 32'h0); hold = 1'b0; flush = 1'b0; #1;
    chk("fh_wb_we", {31'd0, wb_we}, 32'h0);
    chk("fh_arr", rdata1, 32'h10);
    chk("fh_cnt", wr_cnt, 32'h6);

    // Asynchronous reset between edges with a write pending.
    nedge(); ex(1'b1, 5'd11, 32'hBB); raddr1 = 5'd7; raddr2 = 5'd9;
    nedge(); ex(1'b0, 5'd0, 32'h0); #1;
    chk("ar_pre_we", {31'd0, wb_we}, 32'h1);
    #2; rst_n = 1'b0; #1;
    chk("ar_we", {31'd0, wb_we}, 32'h0);
    chk("ar_cnt", wr_cnt, 32'h0);
    chk("ar_x7", rdata1, 32'h0);
    chk("ar_x9", rdata2, 32'h0);
    nedge(); rst_n = 1'b1; raddr1 = 5'd5; #1;
    chk("ar_x5", rdata1, 32'h0);

    // Counter wraps from all-ones to zero.
    nedge();
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    chk("wrap_pre", wr_cnt, 32'hFFFF_FFFF);
    ex(1'b1, 5'd12, 32'h1);
    nedge(); ex(1'b0, 5'd0, 32'h0); #1;
    chk("wrap_cnt", wr_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
